fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard scoreboard for the pipelined CPU, generalising the single-stage MEM/WB read-after-write comparator. It tracks the destination register of every in-flight instruction across DEPTH pipeline stages, and tells each decode read port which stage, if any, to forward from. It raises a load-use stall when the needed value is not yet available. It sits beside the decode stage, is fed by decode and pipeline control, and drives the operand bypass muxes and the decode/fetch stall.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fwd_lookup.sv | 25 ++
 rtl/fwd_scoreboard.sv | 58 +++++
 tb/tb_fwd_scoreboard.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and helpers for the forwarding scoreboard
package cpu_pkg;
    localparam logic [4:0] ZERO_REG = 5'd31;
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } sb_entry_t;
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fwd_lookup.sv
// fwd_lookup: youngest-match forward select for one decode read port
module fwd_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  sb_entry_t [DEPTH:1] entries,
    input  logic      [4:0]     rs,
    input  logic                rs_valid,
    output logic      [SELW-1:0] sel,
    output logic                load_hit
);
    // scanning oldest to youngest lets the youngest match overwrite older ones
    always_comb begin
        sel = '0;
        load_hit = 1'b0;
        for (int k = DEPTH; k >= 1; k--)
            if (rs_valid && rs != ZERO_REG && entries[k].valid && entries[k].regwrite && entries[k].rd == rs) begin
                load_hit = entries[k].is_load && k < LOAD_READY;
                sel = load_hit ? '0 : SELW'(k);
            end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight destinations and drives bypass selects and load-use stall
module fwd_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    localparam int SELW      = sel_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_regwrite,
    input  logic                     issue_is_load,
    input  logic                     hold,
    input  logic                     flush,
    input  logic [NUM_RD*5-1:0]      rs,
    input  logic [NUM_RD-1:0]        rs_valid,
    output logic [NUM_RD*SELW-1:0]   fwd_sel,
    output logic                     load_use_stall,
    output logic [15:0]              fwd_count,
    output logic [15:0]              stall_count
);
    sb_entry_t [DEPTH:1] sb;
    logic [NUM_RD-1:0] load_hit;
    logic issue_ok;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_lookup #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_lookup (
            .entries (sb),
            .rs      (rs[i*5 +: 5]),
            .rs_valid(rs_valid[i]),
            .sel     (fwd_sel[i*SELW +: SELW]),
            .load_hit(load_hit[i])
        );
    end

    assign load_use_stall = |load_hit;
    assign issue_ok = issue_valid && !flush && !load_use_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb          <= '0;
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (hold) begin
                if (flush) sb[1].valid <= 1'b0;
            end else begin
                for (int k = DEPTH; k >= 2; k--) sb[k] <= sb[k-1];
                sb[1] <= issue_ok ? sb_entry_t'{1'b1, issue_rd, issue_regwrite, issue_is_load} : '0;
            end
            if (|fwd_sel && fwd_count != 16'hFFFF) fwd_count <= fwd_count + 16'd1;
            if (load_use_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors with hand-computed expectations for fwd_scoreboard
module tb_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_regwrite, issue_is_load, hold, flush;
    logic [4:0]  issue_rd, rs0, rs1;
    logic [9:0]  rs;
    logic [1:0]  rs_valid;
    logic [3:0]  fwd_sel;
    logic        load_use_stall;
    logic [15:0] fwd_count, stall_count;
    int n_cmp = 0;
    int n_bad = 0;

    assign rs = {rs1, rs0};

    fwd_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load), .hold(hold),
        .flush(flush), .rs(rs), .rs_valid(rs_valid), .fwd_sel(fwd_sel),
        .load_use_stall(load_use_stall), .fwd_count(fwd_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic ld);
        issue_valid = v;
        issue_rd = rd;
        issue_regwrite = rw;
        issue_is_load = ld;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; hold = 0; flush = 0;
        drive(0, 0, 0, 0);
        rs0 = 5'd1; rs1 = 5'd2; rs_valid = 2'b11;
        #12;
        check("rst_sel", fwd_sel, 0);
        check("rst_stall", load_use_stall, 0);
        @(negedge clk) reset = 1'b0;
        tick();
        check("rst_fwd_cnt", fwd_count, 0);
        check("rst_stall_cnt", stall_count, 0);

        drive(1, 5'd3, 1, 0); rs0 = 5'd3; #2;
        check("no_same_cycle", fwd_sel[1:0], 0);
        tick(); drive(0, 0, 0, 0); #2;
        check("dep_stage1", fwd_sel[1:0], 1);
        tick(); check("dep_stage2", fwd_sel[1:0], 2);
        tick(); check("dep_stage3", fwd_sel[1:0], 3);
        tick(); check("dep_retired", fwd_sel[1:0], 0);
        check("fwd_cnt_3", fwd_count, 3);

        drive(1, 5'd5, 1, 0); rs0 = 5'd5; rs1 = 5'd5;
        tick(); tick();
        drive(0, 0, 0, 0); #2;
        check("prio_young", fwd_sel[1:0], 1);
        drive(1, 5'd31, 1, 0); tick(); drive(0, 0, 0, 0); rs0 = 5'd31; #2;
        check("xzr", fwd_sel[1:0], 0);
        check("prio_past_xzr", fwd_sel[3:2], 2);
        drain();

        rs0 = 5'd1; rs1 = 5'd1;
        drive(1, 5'd7, 1, 1); tick();
        drive(1, 5'd8, 1, 0); rs1 = 5'd7; #2;
        check("lu_stall", load_use_stall, 1);
        check("lu_sel_zero", fwd_sel[3:2], 0);
        tick();
        check("lu_released", load_use_stall, 0);
        check("lu_fwd2", fwd_sel[3:2], 2);
        check("lu_stall_cnt", stall_count, 1);
        tick(); drive(0, 0, 0, 0); rs0 = 5'd8; #2;
        check("lu_consumer", fwd_sel[1:0], 1);
        check("lu_bubble", fwd_sel[3:2], 3);
        check("lu_no_restall", load_use_stall, 0);
        drain();

        drive(1, 5'd10, 1, 0); tick();
        drive(1, 5'd11, 1, 0); tick();
        drive(1, 5'd12, 1, 0); tick();
        drive(0, 0, 0, 0); hold = 1; flush = 1; tick();
        hold = 0; flush = 0; rs0 = 5'd12; rs1 = 5'd11; #2;
        check("hf_flushed", fwd_sel[1:0], 0);
        check("hf_stage2", fwd_sel[3:2], 2);
        rs1 = 5'd10; #1;
        check("hf_stage3", fwd_sel[3:2], 3);
        drain();

        rs0 = 5'd1;
        drive(1, 5'd7, 1, 1); tick();
        drive(0, 0, 0, 0); rs1 = 5'd7; #2;
        check("mid_stall", load_use_stall, 1);
        reset = 1'b1; #1;
        check("rst_drops_stall", load_use_stall, 0);
        check("rst_clr_sel", fwd_sel, 0);
        check("rst_clr_cnt", stall_count, 0);
        @(negedge clk) reset = 1'b0;
        tick();
        check("rst_entries_clear", fwd_sel, 0);

        rs0 = 5'd3; rs1 = 5'd1;
        drive(1, 5'd3, 1, 0);
        repeat (70000) tick();
        check("fwd_sat", fwd_count, 16'hFFFF);
        tick();
        check("fwd_sat_hold", fwd_count, 16'hFFFF);
        check("sat_stall_cnt", stall_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
